range_accumulator: RTL and testbench
====================================

RANGE_ACCUMULATOR -- requirements
Module: range_accumulator

Interface
REQ-001 Parameter N_W, default 8, meaning: width of lo/hi/step operands and of the internal term counter.
REQ-002 Parameter ACC_W, default 16, meaning: width of the accumulator and result.
REQ-003 clk  input  1  meaning: single clock; all state updates on the rising edge.
REQ-004 rst  input  1  meaning: reset, asynchronous and active-high.
REQ-005 start  input  1  meaning: request a new accumulation; sampled only in IDLE.
REQ-006 abort  input  1  meaning: cancel a run in progress; sampled only in RUN.
REQ-007 lo, hi, step  input  N_W each  meaning: first term, upper bound, and increment, all unsigned.
REQ-008 mode  input  1  meaning: 0 = sum of terms; 1 = sum of squared terms.
REQ-009 busy  output  1  meaning: high while in RUN.
REQ-010 done  output  1  meaning: one-cycle pulse marking completion.
REQ-011 result  output  ACC_W  meaning: final accumulated value; held until the next accepted start.
REQ-012 overflow  output  1  meaning: sticky flag, set when accumulation exceeded ACC_W bits in the current run.
REQ-013 err  output  1  meaning: set when the configuration was invalid (step==0).

Function
REQ-014 FSM SHALL have three states: IDLE, RUN, DONE; all outputs are Moore/registered, so no input reaches an output combinationally.
REQ-015 IDLE with start=1 SHALL latch lo/hi/step/mode, clear acc/overflow/err, set cnt=lo, and do the following at that edge.
REQ-015a If step==0: go to DONE, set err=1, result=0.
REQ-015b Else if lo>hi: go to DONE with result=0 and err=0 (empty range).
REQ-015c Otherwise: go to RUN.
REQ-016 Each RUN cycle SHALL perform acc += term and cnt += step, where term = cnt (mode 0) or cnt*cnt (mode 1), zero-extended; the counter is computed at N_W+1 bits so it never wraps.
REQ-017 RUN SHALL go to DONE at the edge where cnt+step > hi (compared at N_W+1 bits); the run therefore takes k = floor((hi-lo)/step)+1 cycles.
REQ-018 On entry to DONE, result SHALL take the final acc; done=1 for exactly that one DONE cycle; DONE returns to IDLE unconditionally on the next edge.
REQ-019 Accumulation SHALL wrap modulo 2^ACC_W; any carry out of bit ACC_W-1 (or term bits above ACC_W) SHALL set overflow, which stays high until the next accepted start.
REQ-020 start while in RUN or DONE SHALL be ignored; input changes while in RUN SHALL NOT affect the run in progress.
REQ-021 abort=1 in RUN SHALL go to IDLE at the next edge, leave result/overflow/err unchanged from the previous run, and produce no done pulse; abort has priority over completion in the same cycle.
REQ-022 start and abort asserted together in IDLE SHALL be treated as start alone.
REQ-023 Latency: start accepted at edge E0, done is high during the cycle following edge E0+k (or following E0 for the empty-range and err cases).

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, busy=0, done=0, result=0, overflow=0, err=0, acc=0, cnt=0, regardless of clk.
REQ-025 rst asserted mid-RUN SHALL discard the run; no done pulse occurs after rst is released.
REQ-026 After rst deasserts, the first start SHALL be accepted on the first rising edge at which start=1.

Verification
REQ-027 lo=1, hi=100, step=1, mode=0 -> busy for 100 cycles, done pulse, result=5050, overflow=0, err=0.
REQ-028 lo=1, hi=10, step=3, mode=0 -> 4 RUN cycles (terms 1, 4, 7, 10), result=22; then mode=1, lo=1, hi=10, step=1 -> result=385.
REQ-029 lo=1, hi=100, step=1, mode=1 -> result=10670 (338350 mod 65536), overflow=1.
REQ-030 lo=250, hi=255, step=1, mode=0 (counter near 2^N_W) -> 6 cycles, result=1515, no hang; lo=5, hi=3 -> done one cycle after start, result=0, err=0; step=0 -> done, err=1, result=0.
REQ-031 Abort at RUN cycle 10 of 1..100 -> IDLE, no done, result keeps its prior value; a new start is then accepted and runs to completion.
REQ-032 rst pulse mid-RUN (asynchronous to clk) -> all outputs 0 immediately; start pulsed during RUN is ignored and does not extend or restart the run.

Source files
------------

// File: rtl/range_accumulator.sv
// Multi-cycle accumulator that sums the terms (or their squares) of the arithmetic
// sequence lo, lo+step, ... <= hi, one term per clock, with wrap detection.
module range_accumulator #(
    parameter int N_W   = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [N_W-1:0]   lo,
    input  logic [N_W-1:0]   hi,
    input  logic [N_W-1:0]   step,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] result,
    output logic             overflow,
    output logic             err
);

    localparam int TERM_W = 2 * N_W;
    localparam int SUM_W  = ((ACC_W > TERM_W) ? ACC_W : TERM_W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_W:0]     cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [N_W-1:0]   hi_q, hi_d;
    logic [N_W-1:0]   step_q, step_d;
    logic             mode_q, mode_d;
    logic [ACC_W-1:0] result_q, result_d;
    logic             overflow_q, overflow_d;
    logic             err_q, err_d;

    logic [TERM_W-1:0] term;
    logic [SUM_W-1:0]  sum;
    logic              sum_ovf;
    logic [N_W:0]      cnt_next;

    // The sum is formed wide enough that any carry or oversized term shows up above ACC_W.
    always_comb begin
        if (mode_q) begin
            term = TERM_W'(cnt_q[N_W-1:0]) * TERM_W'(cnt_q[N_W-1:0]);
        end else begin
            term = TERM_W'(cnt_q[N_W-1:0]);
        end
        sum      = SUM_W'(acc_q) + SUM_W'(term);
        sum_ovf  = |sum[SUM_W-1:ACC_W];
        cnt_next = cnt_q + {1'b0, step_q};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        step_d     = step_q;
        mode_d     = mode_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        err_d      = err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d      = {1'b0, lo};
                    hi_d       = hi;
                    step_d     = step;
                    mode_d     = mode;
                    acc_d      = '0;
                    overflow_d = 1'b0;
                    err_d      = 1'b0;
                    if (step == '0) begin
                        err_d    = 1'b1;
                        result_d = '0;
                        state_d  = DONE;
                    end else if (lo > hi) begin
                        result_d = '0;
                        state_d  = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // Abort wins over a completion falling on the same edge.
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    acc_d      = sum[ACC_W-1:0];
                    cnt_d      = cnt_next;
                    overflow_d = overflow_q | sum_ovf;
                    if (cnt_next > {1'b0, hi_q}) begin
                        result_d = sum[ACC_W-1:0];
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            step_q     <= '0;
            mode_q     <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            step_q     <= step_d;
            mode_q     <= mode_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            err_q      <= err_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign result   = result_q;
    assign overflow = overflow_q;
    assign err      = err_q;

endmodule

// File: tb/tb_range_accumulator.sv
// Directed self-checking bench for range_accumulator; expected values are hand-computed
// sums of arithmetic sequences (and their squares) modulo 2^16.
module tb_range_accumulator;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [7:0]  step;
    logic        mode;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        overflow;
    logic        err;

    int total = 0;
    int bad   = 0;
    int cycles;
    int seen;

    range_accumulator #(.N_W(8), .ACC_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .lo       (lo),
        .hi       (hi),
        .step     (step),
        .mode     (mode),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Presents one start request at a negedge and releases it one cycle later.
    task automatic applyStimulus(input logic [7:0] l, input logic [7:0] h,
                                 input logic [7:0] s, input logic m);
        @(negedge clk);
        lo    = l;
        hi    = h;
        step  = s;
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy cycles until done, bounded so a stuck design still reaches the summary.
    task automatic waitDone(input string tag, output int n);
        n = 0;
        for (int i = 0; i < 400 && done !== 1'b1; i++) begin
            if (busy === 1'b1) n++;
            @(negedge clk);
        end
        checkOutput({tag, "_done_seen"}, int'(done), 1);
    endtask

    task automatic checkPulseEnds(input string tag);
        @(negedge clk);
        checkOutput({tag, "_done_one_cycle"}, int'(done), 0);
        checkOutput({tag, "_idle_after"}, int'(busy), 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        lo    = '0;
        hi    = '0;
        step  = '0;
        mode  = 1'b0;
        #12;
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_result", int'(result), 0);
        checkOutput("reset_overflow", int'(overflow), 0);
        checkOutput("reset_err", int'(err), 0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] sum 1..100");
        applyStimulus(8'd1, 8'd100, 8'd1, 1'b0);
        waitDone("sum100", cycles);
        checkOutput("sum100_cycles", cycles, 100);
        checkOutput("sum100_result", int'(result), 5050);
        checkOutput("sum100_overflow", int'(overflow), 0);
        checkOutput("sum100_err", int'(err), 0);
        checkPulseEnds("sum100");

        $display("[TB] sum 1..10 step 3");
        applyStimulus(8'd1, 8'd10, 8'd3, 1'b0);
        waitDone("step3", cycles);
        checkOutput("step3_cycles", cycles, 4);
        checkOutput("step3_result", int'(result), 22);
        checkPulseEnds("step3");

        $display("[TB] squares 1..10");
        applyStimulus(8'd1, 8'd10, 8'd1, 1'b1);
        waitDone("sq10", cycles);
        checkOutput("sq10_cycles", cycles, 10);
        checkOutput("sq10_result", int'(result), 385);
        checkOutput("sq10_overflow", int'(overflow), 0);

        $display("[TB] squares 1..100 wraps");
        applyStimulus(8'd1, 8'd100, 8'd1, 1'b1);
        waitDone("sq100", cycles);
        checkOutput("sq100_result", int'(result), 10670);
        checkOutput("sq100_overflow", int'(overflow), 1);

        $display("[TB] counter near top 250..255");
        applyStimulus(8'd250, 8'd255, 8'd1, 1'b0);
        waitDone("top", cycles);
        checkOutput("top_cycles", cycles, 6);
        checkOutput("top_result", int'(result), 1515);
        checkOutput("top_overflow", int'(overflow), 0);
        checkPulseEnds("top");

        $display("[TB] empty range 5..3");
        applyStimulus(8'd5, 8'd3, 8'd1, 1'b0);
        checkOutput("empty_done_immediate", int'(done), 1);
        checkOutput("empty_result", int'(result), 0);
        checkOutput("empty_err", int'(err), 0);
        checkPulseEnds("empty");

        $display("[TB] zero step");
        applyStimulus(8'd1, 8'd10, 8'd0, 1'b0);
        checkOutput("zstep_done_immediate", int'(done), 1);
        checkOutput("zstep_err", int'(err), 1);
        checkOutput("zstep_result", int'(result), 0);
        checkPulseEnds("zstep");

        $display("[TB] start with abort in IDLE acts as start");
        @(negedge clk);
        lo    = 8'd1;
        hi    = 8'd4;
        step  = 8'd1;
        mode  = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        waitDone("sabort", cycles);
        checkOutput("sabort_cycles", cycles, 4);
        checkOutput("sabort_result", int'(result), 10);
        checkOutput("sabort_err", int'(err), 0);

        $display("[TB] inputs and start ignored during RUN");
        applyStimulus(8'd1, 8'd10, 8'd1, 1'b0);
        repeat (2) @(negedge clk);
        lo    = 8'd50;
        hi    = 8'd200;
        step  = 8'd7;
        mode  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone("ignore", cycles);
        checkOutput("ignore_result", int'(result), 55);
        checkPulseEnds("ignore");
        checkOutput("ignore_no_restart", int'(done), 0);

        $display("[TB] abort mid-run");
        applyStimulus(8'd1, 8'd100, 8'd1, 1'b0);
        repeat (9) @(negedge clk);
        checkOutput("abort_busy_before", int'(busy), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_busy_after", int'(busy), 0);
        seen = 0;
        for (int i = 0; i < 120; i++) begin
            if (done === 1'b1) seen = 1;
            @(negedge clk);
        end
        checkOutput("abort_no_done", seen, 0);
        checkOutput("abort_result_kept", int'(result), 55);
        applyStimulus(8'd1, 8'd10, 8'd1, 1'b0);
        waitDone("after_abort", cycles);
        checkOutput("after_abort_cycles", cycles, 10);
        checkOutput("after_abort_result", int'(result), 55);

        $display("[TB] reset mid-run");
        applyStimulus(8'd1, 8'd100, 8'd1, 1'b1);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_done", int'(done), 0);
        checkOutput("midrst_result", int'(result), 0);
        checkOutput("midrst_overflow", int'(overflow), 0);
        checkOutput("midrst_err", int'(err), 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 120; i++) begin
            if (done === 1'b1 || busy === 1'b1) seen = 1;
            @(negedge clk);
        end
        checkOutput("midrst_stays_idle", seen, 0);
        applyStimulus(8'd2, 8'd8, 8'd2, 1'b0);
        waitDone("post_rst", cycles);
        checkOutput("post_rst_cycles", cycles, 4);
        checkOutput("post_rst_result", int'(result), 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
